// File: rtl/fetch_bundle_queue.sv
// Circular bundle FIFO between fetch and decode; issues one instruction per handshake.
// Optional FETCH_QUEUE_STATS_EN adds saturating push and stall-cycle counters.
module fetch_bundle_queue #(
  parameter int unsigned addressWidth            = 64,
  parameter int unsigned instructionWidth        = 32,
  parameter int unsigned bundleSize              = 128,
  parameter int unsigned PidSize                 = 20,
  parameter int unsigned TidSize                 = 16,
  parameter int unsigned instructionCounterWidth = 64,
  parameter int unsigned queueDepth              = 8,
  parameter int unsigned skidEntries             = 2
) (
  input  logic                                  clock_i,
  input  logic                                  reset_i,
  input  logic                                  flush_i,
  input  logic                                  bundleValid_i,
  input  logic [bundleSize-1:0]                 bundle_i,
  input  logic [addressWidth-1:0]               bundleAddress_i,
  input  logic [1:0]                            bundleLen_i,
  input  logic [PidSize-1:0]                    bundlePid_i,
  input  logic [TidSize-1:0]                    bundleTid_i,
  input  logic [instructionCounterWidth-1:0]    bundleStartMajId_i,
  output logic                                  fetchStall_o,
  output logic                                  instValid_o,
  input  logic                                  instReady_i,
  output logic [instructionWidth-1:0]           inst_o,
  output logic [addressWidth-1:0]               instAddress_o,
  output logic [PidSize-1:0]                    instPid_o,
  output logic [TidSize-1:0]                    instTid_o,
  output logic [instructionCounterWidth-1:0]    instMajId_o,
  output logic                                  overflow_o,
  output logic [$clog2(queueDepth+1)-1:0]       occupancy_o
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]                           pushCount_o,
  output logic [31:0]                           stallCycles_o
`endif
);

  localparam int unsigned PW = $clog2(queueDepth);
  localparam int unsigned OW = $clog2(queueDepth + 1);

  logic [bundleSize-1:0]              r_bundle [queueDepth];
  logic [addressWidth-1:0]            r_addr   [queueDepth];
  logic [1:0]                         r_len    [queueDepth];
  logic [PidSize-1:0]                 r_pid    [queueDepth];
  logic [TidSize-1:0]                 r_tid    [queueDepth];
  logic [instructionCounterWidth-1:0] r_maj    [queueDepth];

  logic [PW-1:0] r_head, r_tail;
  logic [OW-1:0] r_occ;
  logic [1:0]    r_index;
  logic          r_valid, r_stall, r_overflow;

  logic [instructionWidth-1:0]        r_inst;
  logic [addressWidth-1:0]            r_inst_addr;
  logic [PidSize-1:0]                 r_inst_pid;
  logic [TidSize-1:0]                 r_inst_tid;
  logic [instructionCounterWidth-1:0] r_inst_maj;

  logic          w_hs, w_retire, w_full, w_push, w_drop;
  logic [PW-1:0] w_head_n, w_tail_n;
  logic [OW-1:0] w_occ_n;
  logic [1:0]    w_index_n;
  logic          w_valid_n, w_stall_n;

  logic [bundleSize-1:0]              w_src_bundle;
  logic [addressWidth-1:0]            w_src_addr;
  logic [PidSize-1:0]                 w_src_pid;
  logic [TidSize-1:0]                 w_src_tid;
  logic [instructionCounterWidth-1:0] w_src_maj;
  logic [instructionWidth-1:0]        w_inst_n;

  assign w_hs     = r_valid & instReady_i;
  assign w_retire = w_hs & (r_index == r_len[r_head]);
  assign w_full   = (r_occ == OW'(queueDepth));
  assign w_push   = bundleValid_i & ~flush_i & (~w_full | w_retire);
  assign w_drop   = bundleValid_i & ~flush_i & ~w_push;

  always_comb begin
    w_head_n  = r_head;
    w_tail_n  = r_tail;
    w_index_n = r_index;
    w_occ_n   = r_occ;
    if (flush_i) begin
      w_head_n  = '0;
      w_tail_n  = '0;
      w_index_n = '0;
      w_occ_n   = '0;
    end else begin
      if (w_retire) begin
        w_head_n  = r_head + PW'(1);
        w_index_n = '0;
      end else if (w_hs) begin
        w_index_n = r_index + 2'd1;
      end
      if (w_push) w_tail_n = r_tail + PW'(1);
      w_occ_n = r_occ + OW'(w_push) - OW'(w_retire);
    end
    w_valid_n = (w_occ_n != '0);
    w_stall_n = ~flush_i & (w_occ_n >= OW'(queueDepth - skidEntries));
  end

  // The entry becoming head may be the one written this very edge; forward it from the inputs.
  always_comb begin
    if (w_push && (w_head_n == r_tail)) begin
      w_src_bundle = bundle_i;
      w_src_addr   = bundleAddress_i;
      w_src_pid    = bundlePid_i;
      w_src_tid    = bundleTid_i;
      w_src_maj    = bundleStartMajId_i;
    end else begin
      w_src_bundle = r_bundle[w_head_n];
      w_src_addr   = r_addr[w_head_n];
      w_src_pid    = r_pid[w_head_n];
      w_src_tid    = r_tid[w_head_n];
      w_src_maj    = r_maj[w_head_n];
    end
    w_inst_n = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (w_index_n == 2'(k))
        w_inst_n = w_src_bundle[bundleSize-1-instructionWidth*k -: instructionWidth];
    end
  end

  always_ff @(posedge clock_i) begin
    if (w_push) begin
      r_bundle[r_tail] <= bundle_i;
      r_addr[r_tail]   <= bundleAddress_i;
      r_len[r_tail]    <= bundleLen_i;
      r_pid[r_tail]    <= bundlePid_i;
      r_tid[r_tail]    <= bundleTid_i;
      r_maj[r_tail]    <= bundleStartMajId_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_occ       <= '0;
      r_index     <= '0;
      r_valid     <= 1'b0;
      r_stall     <= 1'b0;
      r_overflow  <= 1'b0;
      r_inst      <= '0;
      r_inst_addr <= '0;
      r_inst_pid  <= '0;
      r_inst_tid  <= '0;
      r_inst_maj  <= '0;
    end else begin
      r_head  <= w_head_n;
      r_tail  <= w_tail_n;
      r_occ   <= w_occ_n;
      r_index <= w_index_n;
      r_valid <= w_valid_n;
      r_stall <= w_stall_n;
      if (flush_i)     r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
      if (w_valid_n) begin
        r_inst      <= w_inst_n;
        r_inst_addr <= w_src_addr + {{(addressWidth-4){1'b0}}, w_index_n, 2'b00};
        r_inst_pid  <= w_src_pid;
        r_inst_tid  <= w_src_tid;
        r_inst_maj  <= w_src_maj + {{(instructionCounterWidth-2){1'b0}}, w_index_n};
      end
    end
  end

  assign fetchStall_o  = r_stall;
  assign instValid_o   = r_valid;
  assign inst_o        = r_inst;
  assign instAddress_o = r_inst_addr;
  assign instPid_o     = r_inst_pid;
  assign instTid_o     = r_inst_tid;
  assign instMajId_o   = r_inst_maj;
  assign overflow_o    = r_overflow;
  assign occupancy_o   = r_occ;

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] r_push_cnt, r_stall_cnt;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_push_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_push && (r_push_cnt != '1))   r_push_cnt  <= r_push_cnt + 32'd1;
      if (r_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign pushCount_o   = r_push_cnt;
  assign stallCycles_o = r_stall_cnt;
`endif

endmodule

// File: doc/fetch_bundle_queue.md
Name: fetch_bundle_queue

Overview:
- Decoupling buffer directly downstream of the fetch unit.
- Captures fetched bundles (up to 4 instructions each, with address, PID, TID and start major ID) into a circular FIFO.
- Hands instructions one at a time to decode over a valid/ready handshake, deriving per-instruction address and major ID.
- Back-pressures fetch through a stall output tied to the fetch unit's fetchStall_i.

Parameters:
- addressWidth, 64, instruction address width
- instructionWidth, 32, POWER instruction width
- bundleSize, 128, bundle width (4 instructions)
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, major ID width
- queueDepth, 8, bundle entries (power of two, >=4)
- skidEntries, 2, free entries reserved for in-flight fetches when stall asserts

Ports:
- clock_i  in  1  clock
- reset_i  in  1  asynchronous, active-low reset
- flush_i  in  1  discard all contents (branch redirect)
- bundleValid_i  in  1  fetch outputEnable_o
- bundle_i  in  bundleSize  instruction 0 in MSBs [0:31]
- bundleAddress_i  in  addressWidth  address of instruction 0
- bundleLen_i  in  2  valid instructions minus 1 (0..3 => 1..4)
- bundlePid_i  in  PidSize  PID of bundle
- bundleTid_i  in  TidSize  TID of bundle
- bundleStartMajId_i  in  instructionCounterWidth  major ID of instruction 0
- fetchStall_o  out  1  to fetch unit fetchStall_i
- instValid_o  out  1  instruction available to decode
- instReady_i  in  1  decode accepts this cycle
- inst_o  out  instructionWidth  instruction
- instAddress_o  out  addressWidth  bundleAddress + 4*index
- instPid_o  out  PidSize  PID
- instTid_o  out  TidSize  TID
- instMajId_o  out  instructionCounterWidth  startMajId + index
- overflow_o  out  1  sticky: bundle dropped while full
- occupancy_o  out  clog2(queueDepth+1)  entries held

Behaviour:
- Reset (reset_i low, async): head/tail pointers, index and occupancy 0; instValid_o, fetchStall_o and overflow_o 0; all data outputs 0.
- Storage: queueDepth entries of {bundle, address, len, PID, TID, startMajId}; head/tail pointers wrap modulo queueDepth.
- Push:
  - bundleValid_i captured at posedge into the tail entry.
  - Accepted when occupancy < queueDepth, or when occupancy == queueDepth and the head entry retires the same cycle.
  - Otherwise the bundle is dropped and overflow_o sets; overflow_o clears only on reset or flush_i.
- Pop:
  - Outputs are registered from the head entry and the index register (0..3).
  - Entry visible on instValid_o the cycle after push; an empty-to-first-instruction latency of 1 cycle.
  - A handshake occurs when instValid_o && instReady_i at posedge.
  - On handshake: if index == len, the head retires (index <= 0, head advances); else index increments.
  - Outputs are held stable while instValid_o && !instReady_i.
- Arithmetic:
  - instAddress_o = address + {index,2'b00}, modulo 2^addressWidth.
  - instMajId_o = startMajId + index, modulo 2^instructionCounterWidth.
  - Both wrap silently.
- Simultaneous push and retire: occupancy unchanged; an empty queue receiving a push shows it next cycle.
- Stall: fetchStall_o is registered, = (next occupancy >= queueDepth - skidEntries).
- flush_i (synchronous, highest priority):
  - Next cycle: occupancy 0, index 0, instValid_o 0, fetchStall_o 0, overflow_o 0.
  - A bundle presented with flush_i is discarded.
  - A decode handshake in the flush cycle is still consumed by decode; no further instructions follow.
- Reset asserted mid-operation clears everything immediately, with no partial retire.

Optional Feature:
FETCH_QUEUE_STATS_EN
- Defined:
  - Adds output pushCount_o [0:31], counting accepted bundles.
  - Adds output stallCycles_o [0:31], counting cycles with fetchStall_o high.
  - Both counters saturate at all-ones and clear on reset (not flush).
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single bundle:
  - Stimulus: address 0x1000, len 3, startMajId 10, instReady_i held 1.
  - Required: four instructions on consecutive cycles; addresses 0x1000/0x1004/0x1008/0x100C, majIds 10..13; instValid_o low afterward.
- Partial bundle with back-pressure:
  - Stimulus: len 1, instReady_i 0 for 3 cycles.
  - Required: outputs stable for 3 cycles; 2 instructions delivered after ready rises; occupancy returns to 0.
- Fill to stall:
  - Stimulus: push 6 bundles with ready 0 (depth 8, skid 2).
  - Required: fetchStall_o high the cycle after the 6th push; 2 further pushes accepted; a 9th push sets overflow_o with occupancy 8.
- Full with simultaneous retire:
  - Stimulus: occupancy 8, head on its last instruction, ready 1, push 1.
  - Required: push accepted, occupancy stays 8, overflow_o stays 0.
- Flush mid-bundle:
  - Stimulus: flush_i after 2 of 4 instructions.
  - Required: next cycle instValid_o 0, occupancy 0, fetchStall_o 0; a new bundle at 0x2000 delivers 0x2000 first.
- Wrap and async reset:
  - Stimulus: address 0xFFFF_FFFF_FFFF_FFF8, len 3, ready 1.
  - Required: third instruction address 0x0000_0000_0000_0000.
  - Stimulus: reset_i pulled low mid-bundle, between clock edges.
  - Required: instValid_o 0 immediately.
